// File: rtl/scale_select.sv
// Confirmed wavelet-scale selector: turns noisy per-window minimum-median winners into a
// stable scale choice using consecutive-sample confirmation plus a hysteresis margin.
module scale_select #(
    parameter int unsigned MAX_WINDOW_SIZE = 1024,
    parameter int unsigned CONFIRM_COUNT   = 3,
    parameter int unsigned HYST_MARGIN     = 2,
    parameter int unsigned DEFAULT_SCALE   = 0,
    localparam int unsigned MAX_WINDOW_LOG = $clog2(MAX_WINDOW_SIZE),
    localparam int unsigned MW             = MAX_WINDOW_LOG + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [MW-1:0] min_median_in,
    input  logic [2:0]    min_index_in,
    input  logic          min_valid_in,
    input  logic          clear,
    output logic [2:0]    selected_scale,
    output logic [MW-1:0] selected_median,
    output logic          scale_valid,
    output logic          scale_changed,
    output logic          candidate_active
);

    localparam int unsigned CW = $clog2(CONFIRM_COUNT + 1);
    localparam int unsigned BW = MW + 1;

    typedef enum logic [1:0] {
        ACQUIRE   = 2'd0,
        LOCKED    = 2'd1,
        CANDIDATE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc, acq_cnt;
    logic [2:0]    cand_q, cand_d;
    logic [2:0]    scale_d;
    logic [MW-1:0] median_d;
    logic          changed_d;
    logic          beats;

    // Widened compare so median + margin cannot wrap.
    assign beats = (BW'(min_median_in) + BW'(HYST_MARGIN)) <= BW'(selected_median);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ACQUIRE;
            cnt_q            <= '0;
            cand_q           <= '0;
            selected_scale   <= 3'(DEFAULT_SCALE);
            selected_median  <= '0;
            scale_valid      <= 1'b0;
            scale_changed    <= 1'b0;
            candidate_active <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            cand_q           <= cand_d;
            selected_scale   <= scale_d;
            selected_median  <= median_d;
            scale_valid      <= (state_d != ACQUIRE);
            scale_changed    <= changed_d;
            candidate_active <= (state_d == CANDIDATE);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        scale_d   = selected_scale;
        median_d  = selected_median;
        changed_d = 1'b0;
        cnt_inc   = cnt_q + CW'(1);
        acq_cnt   = CW'(1);

        if (clear) begin
            state_d = ACQUIRE;
            cnt_d   = '0;
        end else if (min_valid_in) begin
            case (state_q)
                ACQUIRE: begin
                    if (cnt_q != '0 && min_index_in == cand_q) begin
                        acq_cnt = cnt_inc;
                    end
                    cand_d = min_index_in;
                    cnt_d  = acq_cnt;
                    if (acq_cnt == CW'(CONFIRM_COUNT)) begin
                        scale_d   = min_index_in;
                        median_d  = min_median_in;
                        changed_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = LOCKED;
                    end
                end
                LOCKED: begin
                    if (min_index_in == selected_scale) begin
                        median_d = min_median_in;
                    end else if (beats) begin
                        cand_d = min_index_in;
                        cnt_d  = CW'(1);
                        if (CONFIRM_COUNT == 1) begin
                            scale_d   = min_index_in;
                            median_d  = min_median_in;
                            changed_d = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            state_d = CANDIDATE;
                        end
                    end
                end
                CANDIDATE: begin
                    if (min_index_in == cand_q && beats) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(CONFIRM_COUNT)) begin
                            scale_d   = cand_q;
                            median_d  = min_median_in;
                            changed_d = 1'b1;
                            cnt_d     = '0;
                            state_d   = LOCKED;
                        end
                    end else if (min_index_in == selected_scale) begin
                        median_d = min_median_in;
                        cnt_d    = '0;
                        state_d  = LOCKED;
                    end else if (beats) begin
                        cand_d = min_index_in;
                        cnt_d  = CW'(1);
                    end else begin
                        cnt_d   = '0;
                        state_d = LOCKED;
                    end
                end
                default: begin
                    state_d = ACQUIRE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/scale_select.md
Name: scale_select

Overview:
- Downstream consumer of the 8-way minimum-median reducer.
- Takes the per-window winning scale index and its median, and applies count-based confirmation plus a hysteresis margin.
- Publishes a stable selected wavelet scale to the reconstruction/threshold stage, so that noisy winners do not cause scale thrashing.

Parameters:
MAX_WINDOW_SIZE, 1024, window length; sets the median width.
MAX_WINDOW_LOG, $clog2(MAX_WINDOW_SIZE), localparam; the median is MAX_WINDOW_LOG+1 bits wide.
CONFIRM_COUNT, 3, number of consecutive valid results that must agree before acquiring or switching (>=1).
HYST_MARGIN, 2, amount by which a challenger median must undercut the tracked median, in median LSBs.
DEFAULT_SCALE, 0, value of selected_scale out of reset.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
min_median_in  in  MAX_WINDOW_LOG+1  winning (minimum) median from the reducer.
min_index_in  in  3  index 0..7 of the winning scale.
min_valid_in  in  1  qualifies min_median_in and min_index_in; 1-cycle strobe per window.
clear  in  1  synchronous re-acquire request.
selected_scale  out  3  confirmed scale index.
selected_median  out  MAX_WINDOW_LOG+1  last median recorded for selected_scale.
scale_valid  out  1  high while a scale is confirmed.
scale_changed  out  1  1-cycle pulse when selected_scale is (re)written by a confirmation.
candidate_active  out  1  high while a challenger is being counted.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values (immediate on rst_n low, including mid-operation):
  - state=ACQUIRE, cnt=0, cand_idx=0.
  - selected_scale=DEFAULT_SCALE, selected_median=0.
  - scale_valid=0, scale_changed=0, candidate_active=0.
- Registered outputs: the effect of a valid sample is visible the cycle after it is sampled (latency 1).
- Counting rule: counts are in valid samples, not cycles. Idle cycles between strobes neither advance nor reset cnt.
- cnt width: $clog2(CONFIRM_COUNT+1).
- Default per cycle: scale_changed=0.
- Margin test ("beats"): min_median_in + HYST_MARGIN <= selected_median, evaluated at MAX_WINDOW_LOG+2 bits so the sum cannot overflow.
- State ACQUIRE, on valid:
  - If cnt>0 and min_index_in==cand_idx: cnt++. Otherwise cand_idx<=min_index_in and cnt<=1.
  - When the new count equals CONFIRM_COUNT:
    - selected_scale<=min_index_in, selected_median<=min_median_in.
    - scale_valid<=1, scale_changed<=1, cnt<=0, go to LOCKED.
- State LOCKED, on valid:
  - min_index_in==selected_scale: selected_median<=min_median_in (tracking only, no pulse).
  - Other index that beats: cand_idx<=index and cnt<=1.
    - If CONFIRM_COUNT==1, switch immediately (see switch).
    - Otherwise go to CANDIDATE.
  - Other index that does not beat: ignored.
- State CANDIDATE, on valid:
  - index==cand_idx and beats: cnt++. Reaching CONFIRM_COUNT triggers a switch.
  - index==selected_scale: update selected_median, cnt<=0, go to LOCKED.
  - Different index that beats: cand_idx<=index, cnt<=1, stay in CANDIDATE.
  - Any non-beating sample: cnt<=0, go to LOCKED.
- Switch:
  - selected_scale<=cand_idx, selected_median<=min_median_in, scale_changed<=1.
  - cnt<=0, go to LOCKED.
- candidate_active = (state==CANDIDATE), registered.
- scale_valid = 1 in LOCKED and CANDIDATE.
- clear (synchronous, highest priority after reset):
  - state<=ACQUIRE, cnt<=0, scale_valid<=0.
  - selected_scale and selected_median hold their values.
  - A valid strobe in the same cycle as clear is discarded.
- Acquiring again after clear pulses scale_changed even if the index is the same as before.
- Indices are always 0..7; there is no illegal-index handling.

Test Plan:
Unless stated, CONFIRM_COUNT=3 and HYST_MARGIN=2.
1. Acquire: after reset, 3 strobes of idx5/med100, with 2 idle cycles between them.
   -> Cycle after the 3rd strobe: selected_scale=5, selected_median=100, scale_valid=1, scale_changed high for exactly 1 cycle.
   -> Before that: scale_valid=0, selected_scale=0.
2. Broken acquire: idx 5,5,2,2,2 (med 50).
   -> Locks on 2 after the 5th strobe. No scale_changed before it.
3. Hysteresis reject: locked on 5/med100; 5 strobes of idx3/med99.
   -> No change; candidate_active stays 0; selected_median stays 100.
4. Switch: locked on 5/med100; 3 strobes of idx3/med98.
   -> candidate_active=1 after the 1st strobe.
   -> After the 3rd: selected_scale=3, selected_median=98, 1-cycle scale_changed, candidate_active=0.
5. Cancel: locked on 5/med100; then 3/90, 5/100, 3/90, 3/90.
   -> No switch and selected_median=100. A further 3/90 causes the switch.
6. Clear and reset:
   -> clear coincident with a valid strobe: scale_valid=0 next cycle and the sample is not counted.
   -> rst_n low mid-CANDIDATE: all outputs at reset values without a clock edge.
